// File: rtl/jk_bank_if.sv
// jk_bank_if: requester handshakes and JK bank drive/feedback lines for jk_bank_scheduler
interface jk_bank_if #(
   parameter int N  = 4,
   parameter int CW = 4
);
   logic          req_a_valid, req_b_valid, req_a_ready, req_b_ready;
   logic [1:0]    req_a_op, req_b_op;
   logic [N-1:0]  req_a_mask, req_b_mask;
   logic [CW-1:0] req_a_cnt, req_b_cnt;
   logic [N-1:0]  j, k, q_in, result;
   logic          busy, grant_b, done;
   modport master (
      output req_a_valid, req_a_op, req_a_mask, req_a_cnt,
      output req_b_valid, req_b_op, req_b_mask, req_b_cnt, q_in,
      input  req_a_ready, req_b_ready, j, k, busy, grant_b, done, result
   );
   modport slave (
      input  req_a_valid, req_a_op, req_a_mask, req_a_cnt,
      input  req_b_valid, req_b_op, req_b_mask, req_b_cnt, q_in,
      output req_a_ready, req_b_ready, j, k, busy, grant_b, done, result
   );
endinterface

// File: rtl/jk_bank_scheduler.sv
// jk_bank_scheduler: round-robin arbiter applying latched J/K commands to an external flip-flop bank
module jk_bank_scheduler #(
   parameter int N  = 4,
   parameter int CW = 4
) (
   input logic      clk,
   input logic      rst,
   jk_bank_if.slave bus
);
   typedef enum logic [1:0] {IDLE, APPLY, SETTLE, DONE} state_t;
   state_t        state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [N-1:0]  mask_q, mask_d, result_q, result_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_in;
   logic          grant_b_q, grant_b_d, last_b_q, last_b_d;
   logic          idle, apply, ready_a, ready_b;
   always_comb begin
      idle = !rst && state_q == IDLE;
      apply = !rst && state_q == APPLY;
      // A wins a contest unless it was the last one granted
      ready_a = idle && bus.req_a_valid && (!bus.req_b_valid || last_b_q);
      ready_b = idle && bus.req_b_valid && !ready_a;
      cnt_in = ready_b ? bus.req_b_cnt : bus.req_a_cnt;
      state_d = state_q;
      op_d = op_q;
      mask_d = mask_q;
      cnt_d = cnt_q;
      grant_b_d = grant_b_q;
      last_b_d = last_b_q;
      result_d = result_q;
      case (state_q)
         IDLE: if (ready_a || ready_b) begin
            state_d = APPLY;
            op_d = ready_b ? bus.req_b_op : bus.req_a_op;
            mask_d = ready_b ? bus.req_b_mask : bus.req_a_mask;
            cnt_d = cnt_in == '0 ? CW'(1) : cnt_in;
            grant_b_d = ready_b;
            last_b_d = ready_b;
         end
         APPLY: begin
            state_d = cnt_q <= CW'(1) ? SETTLE : APPLY;
            cnt_d = cnt_q - CW'(1);
         end
         SETTLE: begin
            state_d = DONE;
            result_d = bus.q_in;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q <= '0;
         mask_q <= '0;
         cnt_q <= '0;
         grant_b_q <= 1'b0;
         last_b_q <= 1'b1;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         mask_q <= mask_d;
         cnt_q <= cnt_d;
         grant_b_q <= grant_b_d;
         last_b_q <= last_b_d;
         result_q <= result_d;
      end
   end
   assign bus.req_a_ready = ready_a;
   assign bus.req_b_ready = ready_b;
   assign bus.j = apply && op_q[1] ? mask_q : '0;
   assign bus.k = apply && op_q[0] ? mask_q : '0;
   assign bus.busy = !rst && state_q != IDLE;
   assign bus.done = !rst && state_q == DONE;
   assign bus.grant_b = grant_b_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_jk_bank_scheduler.sv
// tb_jk_bank_scheduler: directed table, corner sequences and random traffic against a transaction model
module tb_jk_bank_scheduler;
   localparam int N = 4;
   localparam int CW = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   jk_bank_if #(.N(N), .CW(CW)) bus ();
   jk_bank_scheduler #(.N(N), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
   logic [N-1:0] bank_q;
   always_ff @(posedge clk) bank_q <= rst ? '0 : (bank_q & ~bus.k) | (~bank_q & bus.j);
   assign bus.q_in = bank_q;
   int checks = 0;
   int errors = 0;
   typedef struct {
      logic         use_b;
      logic [1:0]   op;
      logic [N-1:0] mask;
      logic [CW-1:0] cnt;
      int           napply;
      logic [N-1:0] ej, ek, eres;
   } vec_t;
   vec_t tbl[7];
   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask
   task automatic chkn(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask
   task automatic idle_inputs();
      bus.req_a_valid = 1'b0;
      bus.req_b_valid = 1'b0;
   endtask
   task automatic drive(input logic b, input logic [1:0] op, input logic [N-1:0] m, input logic [CW-1:0] c);
      if (b) begin
         bus.req_b_valid = 1'b1; bus.req_b_op = op; bus.req_b_mask = m; bus.req_b_cnt = c;
      end else begin
         bus.req_a_valid = 1'b1; bus.req_a_op = op; bus.req_a_mask = m; bus.req_a_cnt = c;
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask
   function automatic logic [N-1:0] apply_op(input logic [N-1:0] q, input logic [1:0] op, input logic [N-1:0] m, input int c);
      return op == 2'd1 ? q & ~m : op == 2'd2 ? q | m : op == 2'd3 ? ((c % 2) == 1 ? q ^ m : q) : q;
   endfunction
   task automatic run_vec(input vec_t v, input int idx);
      logic got;
      @(negedge clk);
      drive(v.use_b, v.op, v.mask, v.cnt);
      #1;
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
         got = v.use_b ? bus.req_b_ready : bus.req_a_ready;
         if (!got) begin @(negedge clk); #1; end
      end
      chk1($sformatf("v%0d accept", idx), got, 1'b1);
      chk1($sformatf("v%0d other_ready", idx), v.use_b ? bus.req_a_ready : bus.req_b_ready, 1'b0);
      for (int i = 1; i <= v.napply; i++) begin
         @(negedge clk);
         if (i == 1) begin
            idle_inputs();
            bus.req_a_op = 2'($urandom); bus.req_a_mask = N'($urandom);
            bus.req_b_op = 2'($urandom); bus.req_b_mask = N'($urandom);
         end
         #1;
         chkn($sformatf("v%0d apply%0d j", idx, i), bus.j, v.ej);
         chkn($sformatf("v%0d apply%0d k", idx, i), bus.k, v.ek);
         chk1($sformatf("v%0d apply%0d busy", idx, i), bus.busy, 1'b1);
         chk1($sformatf("v%0d apply%0d done", idx, i), bus.done, 1'b0);
      end
      @(negedge clk); #1;
      chkn($sformatf("v%0d settle jk", idx), bus.j | bus.k, '0);
      chk1($sformatf("v%0d settle done", idx), bus.done, 1'b0);
      chk1($sformatf("v%0d grant_b", idx), bus.grant_b, v.use_b);
      @(negedge clk); #1;
      chk1($sformatf("v%0d done", idx), bus.done, 1'b1);
      chkn($sformatf("v%0d done jk", idx), bus.j | bus.k, '0);
      chkn($sformatf("v%0d result", idx), bus.result, v.eres);
      @(negedge clk); #1;
      chk1($sformatf("v%0d done_after", idx), bus.done, 1'b0);
      chk1($sformatf("v%0d busy_after", idx), bus.busy, 1'b0);
      chkn($sformatf("v%0d result_held", idx), bus.result, v.eres);
   endtask
   initial begin
      logic [8:0] era, erb, egb, edn;
      logic saw_done;
      int t_acc, c_acc;
      logic [1:0] op_m;
      logic [N-1:0] mask_m, res_old, res_new, je, ke, res_e;
      logic g_old, g_new, last_m, busy_e, apply_e, done_e, gb_e, ra_e, rb_e;
      // bank starts at 0000 after each reset; later rows build on earlier results
      tbl[0] = '{1'b0, 2'b10, 4'b1010, 4'd1, 1, 4'b1010, 4'b0000, 4'b1010};
      tbl[1] = '{1'b0, 2'b00, 4'b1111, 4'd2, 2, 4'b0000, 4'b0000, 4'b1010};
      tbl[2] = '{1'b0, 2'b10, 4'b1111, 4'd1, 1, 4'b1111, 4'b0000, 4'b1111};
      tbl[3] = '{1'b0, 2'b01, 4'b1111, 4'd0, 1, 4'b0000, 4'b1111, 4'b0000};
      tbl[4] = '{1'b1, 2'b11, 4'b0011, 4'd3, 3, 4'b0011, 4'b0011, 4'b0011};
      tbl[5] = '{1'b1, 2'b11, 4'b0110, 4'd15, 15, 4'b0110, 4'b0110, 4'b0101};
      tbl[6] = '{1'b0, 2'b11, 4'b1111, 4'd2, 2, 4'b1111, 4'b1111, 4'b0101};
      idle_inputs();
      bus.req_a_op = 2'b10; bus.req_a_mask = '1; bus.req_a_cnt = '0;
      bus.req_b_op = 2'b10; bus.req_b_mask = '1; bus.req_b_cnt = '0;
      bus.req_a_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk1("rst ready_a", bus.req_a_ready, 1'b0);
      chk1("rst busy", bus.busy, 1'b0);
      chk1("rst done", bus.done, 1'b0);
      chk1("rst grant_b", bus.grant_b, 1'b0);
      chkn("rst result", bus.result, '0);
      chkn("rst jk", bus.j | bus.k, '0);
      // both requesters contend on the first cycle out of reset
      era = 9'b000000001; erb = 9'b000010000; egb = 9'b111100000; edn = 9'b010001000;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 2'b10, 4'b1010, 4'd1);
      drive(1'b1, 2'b11, 4'b0011, 4'd1);
      for (int c = 0; c < 9; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1) bus.req_a_valid = 1'b0;
         if (c == 5) bus.req_b_valid = 1'b0;
         #1;
         chk1($sformatf("rr c%0d ready_a", c), bus.req_a_ready, era[c]);
         chk1($sformatf("rr c%0d ready_b", c), bus.req_b_ready, erb[c]);
         chk1($sformatf("rr c%0d grant_b", c), bus.grant_b, egb[c]);
         chk1($sformatf("rr c%0d done", c), bus.done, edn[c]);
      end
      chkn("rr result", bus.result, 4'b1001);
      do_reset();
      for (int i = 0; i < 7; i++) run_vec(tbl[i], i);
      // reset lands on the second apply cycle of a toggle
      @(negedge clk);
      drive(1'b0, 2'b11, 4'b1111, 4'd4);
      #1;
      chk1("abort accept", bus.req_a_ready, 1'b1);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chkn("abort jk during rst", bus.j | bus.k, '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chkn("abort j", bus.j, '0);
      chkn("abort k", bus.k, '0);
      chk1("abort busy", bus.busy, 1'b0);
      chkn("abort result", bus.result, '0);
      saw_done = bus.done;
      repeat (6) begin
         @(negedge clk); #1;
         saw_done = saw_done | bus.done;
      end
      chk1("abort no done", saw_done, 1'b0);
      // random traffic against a timeline model of each accepted command
      do_reset();
      t_acc = -100; c_acc = 1; op_m = '0; mask_m = '0;
      res_old = '0; res_new = '0; g_old = 1'b0; g_new = 1'b0; last_m = 1'b1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         bus.req_a_valid = 1'($urandom_range(0, 1));
         bus.req_b_valid = 1'($urandom_range(0, 1));
         bus.req_a_op = 2'($urandom); bus.req_a_mask = N'($urandom);
         bus.req_b_op = 2'($urandom); bus.req_b_mask = N'($urandom);
         bus.req_a_cnt = $urandom_range(0, 7) == 0 ? CW'(15) : CW'($urandom_range(0, 4));
         bus.req_b_cnt = $urandom_range(0, 7) == 0 ? CW'(15) : CW'($urandom_range(0, 4));
         #1;
         busy_e = cyc > t_acc && cyc <= t_acc + c_acc + 2;
         apply_e = cyc > t_acc && cyc <= t_acc + c_acc;
         done_e = cyc == t_acc + c_acc + 2;
         je = apply_e && op_m[1] ? mask_m : '0;
         ke = apply_e && op_m[0] ? mask_m : '0;
         res_e = cyc >= t_acc + c_acc + 2 ? res_new : res_old;
         gb_e = cyc > t_acc ? g_new : g_old;
         ra_e = !busy_e && bus.req_a_valid && (!bus.req_b_valid || last_m);
         rb_e = !busy_e && bus.req_b_valid && !ra_e;
         chk1($sformatf("rnd %0d ready_a", cyc), bus.req_a_ready, ra_e);
         chk1($sformatf("rnd %0d ready_b", cyc), bus.req_b_ready, rb_e);
         chk1($sformatf("rnd %0d busy", cyc), bus.busy, busy_e);
         chk1($sformatf("rnd %0d done", cyc), bus.done, done_e);
         chk1($sformatf("rnd %0d grant_b", cyc), bus.grant_b, gb_e);
         chkn($sformatf("rnd %0d j", cyc), bus.j, je);
         chkn($sformatf("rnd %0d k", cyc), bus.k, ke);
         chkn($sformatf("rnd %0d result", cyc), bus.result, res_e);
         if (ra_e || rb_e) begin
            res_old = res_e;
            g_old = g_new;
            g_new = rb_e;
            last_m = rb_e;
            t_acc = cyc;
            c_acc = int'(rb_e ? bus.req_b_cnt : bus.req_a_cnt);
            if (c_acc == 0) c_acc = 1;
            op_m = rb_e ? bus.req_b_op : bus.req_a_op;
            mask_m = rb_e ? bus.req_b_mask : bus.req_a_mask;
            res_new = apply_op(res_e, op_m, mask_m, c_acc);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jk_bank_scheduler.md
JK_BANK_SCHEDULER -- requirements
Module: jk_bank_scheduler

Interface
REQ-001 Parameter N, default 4, SHALL set the width of the controlled JK flip-flop bank.
REQ-002 Parameter CW, default 4, SHALL set the width of the repeat-count field.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req_a_valid / req_b_valid  input  1  requester A/B has a command pending.
REQ-006 req_a_op / req_b_op  input  2  00 hold, 01 reset (K), 10 set (J), 11 toggle (J=K=1).
REQ-007 req_a_mask / req_b_mask  input  N  bank bits the command affects.
REQ-008 req_a_cnt / req_b_cnt  input  CW  number of apply cycles; 0 SHALL be treated as 1.
REQ-009 req_a_ready / req_b_ready  output  1  command accepted this cycle (valid & ready = accept).
REQ-010 j / k  output  N  drive lines to the external JK bank.
REQ-011 q_in  input  N  state fed back from the external JK bank.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 grant_b  output  1  owner of the command in flight (0 = A, 1 = B), held until the next accept.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 result  output  N  q_in snapshot for the last completed command, held until the next completion.

Function
REQ-016 FSM states SHALL be IDLE, APPLY, SETTLE and DONE only.
REQ-017 In IDLE, at most one ready SHALL be high, and only to a valid requester.
- Only one valid: grant it.
- Both valid: grant the requester not granted last (round-robin).
REQ-018 On accept, the op, mask and count SHALL be latched, grant_b updated, and the state SHALL go to APPLY on the next cycle.
REQ-019 Ready SHALL be combinational from IDLE, the valid inputs and last-grant state, and SHALL be 0 outside IDLE.
REQ-020 In APPLY, for each bit i, j[i] and k[i] SHALL follow the latched op ANDed with mask[i]; unmasked bits SHALL have j=k=0.
REQ-021 APPLY SHALL last exactly max(cnt,1) cycles, then go to SETTLE.
REQ-022 In SETTLE, j=k=0 and result SHALL be loaded from q_in at the end of the cycle; then go to DONE.
REQ-023 In DONE, done=1 for exactly one cycle, j=k=0, then go to IDLE.
REQ-024 Accept-to-done latency SHALL be: accept in cycle T, done in cycle T+max(cnt,1)+2.
REQ-025 Back-to-back: the earliest next accept SHALL be the cycle after DONE.
REQ-026 Requests deasserted or changed while busy SHALL be ignored and SHALL NOT affect the command in flight.
REQ-027 j and k SHALL be 0 in IDLE, SETTLE and DONE, and SHALL NOT both be 1 for any op other than toggle.
REQ-028 Count decrement SHALL NOT wrap; cnt = 2^CW-1 SHALL give exactly 2^CW-1 apply cycles.

Reset
REQ-029 While rst is high, the state SHALL be IDLE, j=k=0, done=0, result=0, grant_b=0, and both readies 0.
REQ-030 Reset SHALL set last-grant to B, so A wins the first contested arbitration.
REQ-031 Reset asserted during APPLY or SETTLE SHALL abort the command with no done pulse, and j/k SHALL be 0 from the next cycle.

Verification
REQ-032 The bench SHALL pair the block with N JK flip-flops (q fed back to q_in) and cover these scenarios:
- A: set, mask 1010, cnt 1 -> done 3 cycles after accept, result 1010.
- Both requesters valid, each with a command, on the first cycle after reset -> A granted first, B accepted the cycle after A's DONE, grant_b 0 then 1.
- B: toggle, mask 0011, cnt 3, from 0000 -> j=k=0011 for 3 cycles, result 0011, done at T+5.
- A: reset, mask 1111, cnt 0 from 1111 -> one APPLY cycle, result 0000, done at T+3.
- rst pulsed during the second cycle of a toggle, cnt 4 -> no done, j=k=0 next cycle, busy=0, result 0000.
- A: hold, cnt 2 -> j=k=0 throughout, result equals prior q_in, done at T+4.
